// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory port between instruction fetch (IF)
//               and load/store (DM). One outstanding access, fixed read
//               latency, DM priority with an IF anti-starvation limit.
//               Define ARB_ROUND_ROBIN_EN for alternating priority instead.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
`ifndef ARB_ROUND_ROBIN_EN
    ,
    parameter int STARVE_MAX = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    // instruction fetch side
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    // load/store side
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_wstrb,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [2:0]    c_LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [AW-1:0] c_ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};
    localparam logic          c_OWNER_IF   = 1'b0;
    localparam logic          c_OWNER_DM   = 1'b1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_we;
    logic       w_we_nxt;

    logic       w_done;
    logic       w_free;
    logic       w_gnt;
    logic       w_pick_dm;
    logic       w_rvalid;

    // The rvalid cycle doubles as an idle cycle so a new grant can overlap it.
    always_comb begin
        w_done   = (r_state == S_WAIT) && (r_cnt == 3'd0);
        w_free   = (r_state == S_IDLE) || w_done;
        w_gnt    = !rst && w_free && (if_req || dm_req);
        w_rvalid = !rst && w_done;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // The previous owner loses a tie.
    always_comb begin
        w_pick_dm = dm_req && (!if_req || (r_owner == c_OWNER_IF));
    end
`else
    localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] r_starve;

    always_comb begin
        w_pick_dm = dm_req && (!if_req || (r_starve != c_STARVE_LIM));
    end

    // Counts DM wins over a waiting fetch; any other grant resets the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (w_gnt) begin
            if (w_pick_dm && if_req) begin
                if (r_starve != c_STARVE_LIM) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else begin
                r_starve <= 4'd0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_owner <= c_OWNER_IF;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_we    <= w_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_we_nxt    = r_we;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_gnt) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_LAT_LOAD;
            w_owner_nxt = w_pick_dm ? c_OWNER_DM : c_OWNER_IF;
            w_we_nxt    = w_pick_dm && dm_we;
        end
    end

    always_comb begin
        if_gnt    = w_gnt && !w_pick_dm;
        dm_gnt    = w_gnt && w_pick_dm;
        if_rvalid = w_rvalid && (r_owner == c_OWNER_IF);
        dm_rvalid = w_rvalid && (r_owner == c_OWNER_DM);
        if_rdata  = if_rvalid ? mem_rdata : 32'd0;
        dm_rdata  = (dm_rvalid && !r_we) ? mem_rdata : 32'd0;
        mem_en    = w_gnt;
        mem_we    = w_gnt && w_pick_dm && dm_we;
        mem_wstrb = mem_we ? dm_wstrb : 4'd0;
        mem_addr  = (w_pick_dm ? dm_addr : if_addr) & c_ALIGN_MASK;
        mem_wdata = dm_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter; two instances
//               (MEM_LAT=1 and MEM_LAT=3) against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int NI = 2;
`ifndef ARB_ROUND_ROBIN_EN
    localparam int SMAX = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [NI];
    logic          if_req    [NI];
    logic [AW-1:0] if_addr   [NI];
    logic          if_gnt    [NI];
    logic          if_rvalid [NI];
    logic [31:0]   if_rdata  [NI];
    logic          dm_req    [NI];
    logic          dm_we     [NI];
    logic [3:0]    dm_wstrb  [NI];
    logic [AW-1:0] dm_addr   [NI];
    logic [31:0]   dm_wdata  [NI];
    logic          dm_gnt    [NI];
    logic          dm_rvalid [NI];
    logic [31:0]   dm_rdata  [NI];
    logic          mem_en    [NI];
    logic          mem_we    [NI];
    logic [3:0]    mem_wstrb [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [31:0]   mem_wdata [NI];
    logic [31:0]   mem_rdata [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mem_port_arbiter #(
                .AW      (AW),
                .MEM_LAT ((g == 0) ? 1 : 3)
            ) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .if_req    (if_req[g]),
                .if_addr   (if_addr[g]),
                .if_gnt    (if_gnt[g]),
                .if_rvalid (if_rvalid[g]),
                .if_rdata  (if_rdata[g]),
                .dm_req    (dm_req[g]),
                .dm_we     (dm_we[g]),
                .dm_wstrb  (dm_wstrb[g]),
                .dm_addr   (dm_addr[g]),
                .dm_wdata  (dm_wdata[g]),
                .dm_gnt    (dm_gnt[g]),
                .dm_rvalid (dm_rvalid[g]),
                .dm_rdata  (dm_rdata[g]),
                .mem_en    (mem_en[g]),
                .mem_we    (mem_we[g]),
                .mem_wstrb (mem_wstrb[g]),
                .mem_addr  (mem_addr[g]),
                .mem_wdata (mem_wdata[g]),
                .mem_rdata (mem_rdata[g])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: one pending transaction with a due cycle, plus memory.
    bit          pend_v    [NI];
    int          pend_due  [NI];
    bit          pend_dm   [NI];
    logic [31:0] pend_data [NI];
    int          starve    [NI];
    bit          last_dm   [NI];
    logic [31:0] mmem      [NI][128];
    // Memory environment: array plus fixed-latency read return slots.
    logic [31:0] emem      [NI][128];
    bit          rp_v      [NI][8];
    logic [31:0] rp_d      [NI][8];
    // Handshakes seen in the last cycle, for the request drivers.
    bit saw_ig [NI];
    bit saw_dg [NI];
    bit saw_irv[NI];
    bit saw_drv[NI];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // One clock for every instance: drive memory data, check at negedge, update.
    task automatic cycle();
        for (int k = 0; k < NI; k++) begin
            mem_rdata[k] = rp_v[k][cyc % 8] ? rp_d[k][cyc % 8] : $urandom();
            rp_v[k][cyc % 8] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            bit rv, fr, gi, gd;
            int w;
            rv = !rst[k] && pend_v[k] && (pend_due[k] == cyc);
            fr = !pend_v[k] || (pend_due[k] == cyc);
            gi = 1'b0;
            gd = 1'b0;
            if (!rst[k] && fr && (if_req[k] || dm_req[k])) begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = dm_req[k] && (!if_req[k] || !last_dm[k]);
`else
                gd = dm_req[k] && (!if_req[k] || (starve[k] < SMAX));
`endif
                gi = !gd;
            end
            chk("if_gnt",    64'(if_gnt[k]),    64'(gi));
            chk("dm_gnt",    64'(dm_gnt[k]),    64'(gd));
            chk("mem_en",    64'(mem_en[k]),    64'(gi | gd));
            chk("if_rvalid", 64'(if_rvalid[k]), 64'(rv && !pend_dm[k]));
            chk("dm_rvalid", 64'(dm_rvalid[k]), 64'(rv && pend_dm[k]));
            chk("if_rdata",  64'(if_rdata[k]),  64'((rv && !pend_dm[k]) ? pend_data[k] : 32'd0));
            chk("dm_rdata",  64'(dm_rdata[k]),  64'((rv && pend_dm[k]) ? pend_data[k] : 32'd0));
            if (gi || gd) begin
                logic [AW-1:0] a;
                a = gd ? dm_addr[k] : if_addr[k];
                chk("mem_addr",  64'(mem_addr[k]),  64'({a[AW-1:2], 2'b00}));
                chk("mem_we",    64'(mem_we[k]),    64'(gd && dm_we[k]));
                chk("mem_wstrb", 64'(mem_wstrb[k]), 64'((gd && dm_we[k]) ? dm_wstrb[k] : 4'd0));
                if (gd && dm_we[k]) chk("mem_wdata", 64'(mem_wdata[k]), 64'(dm_wdata[k]));
            end
            saw_ig[k]  = if_gnt[k];
            saw_dg[k]  = dm_gnt[k];
            saw_irv[k] = if_rvalid[k];
            saw_drv[k] = dm_rvalid[k];
            // memory environment follows what the DUT actually issued
            if (mem_en[k]) begin
                w = int'(mem_addr[k][8:2]);
                if (mem_we[k]) begin
                    emem[k][w] = merge(emem[k][w], mem_wdata[k], mem_wstrb[k]);
                end else begin
                    rp_v[k][(cyc + lat_of(k)) % 8] = 1'b1;
                    rp_d[k][(cyc + lat_of(k)) % 8] = emem[k][w];
                end
            end
            // model update
            if (rst[k]) begin
                pend_v[k]  = 1'b0;
                starve[k]  = 0;
                last_dm[k] = 1'b0;
            end else begin
                if (pend_v[k] && (pend_due[k] == cyc)) pend_v[k] = 1'b0;
                if (gi || gd) begin
                    pend_v[k]   = 1'b1;
                    pend_due[k] = cyc + lat_of(k);
                    pend_dm[k]  = gd;
                    last_dm[k]  = gd;
                    w = gd ? int'(dm_addr[k][8:2]) : int'(if_addr[k][8:2]);
                    if (gd && dm_we[k]) begin
                        mmem[k][w]   = merge(mmem[k][w], dm_wdata[k], dm_wstrb[k]);
                        pend_data[k] = 32'd0;
                    end else begin
                        pend_data[k] = mmem[k][w];
                    end
                    if (gd && if_req[k]) begin
                        starve[k] = starve[k] + 1;
`ifndef ARB_ROUND_ROBIN_EN
                        if (starve[k] > SMAX) starve[k] = SMAX;
`endif
                    end else begin
                        starve[k] = 0;
                    end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_granted();
        for (int k = 0; k < NI; k++) begin
            if (saw_ig[k]) if_req[k] = 1'b0;
            if (saw_dg[k]) dm_req[k] = 1'b0;
        end
    endtask

    function automatic bit any_req();
        bit r;
        r = 1'b0;
        for (int k = 0; k < NI; k++) r = r | if_req[k] | dm_req[k];
        return r;
    endfunction

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while (any_req() && (n < maxc)) begin
            cycle();
            drop_granted();
            n++;
        end
        chk("req_timeout", 64'(any_req()), 64'd0);
        repeat (4) cycle();
    endtask

    task automatic set_dm(input int k, input bit we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        dm_req[k]   = 1'b1;
        dm_we[k]    = we;
        dm_addr[k]  = a;
        dm_wdata[k] = d;
        dm_wstrb[k] = s;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrv, first, last, nd, ni;
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 128; w++) begin
                logic [31:0] v;
                v = $urandom();
                mmem[k][w] = v;
                emem[k][w] = v;
            end
            for (int s = 0; s < 8; s++) rp_v[k][s] = 1'b0;
            rst[k] = 1'b1;
            if_req[k] = 1'b1;
            if_addr[k] = AW'($urandom_range(0, 63));
            set_dm(k, 1'b0, AW'($urandom_range(0, 63)), 32'd0, 4'd0);
            mem_rdata[k] = 32'd0;
            pend_v[k] = 1'b0;
            pend_dm[k] = 1'b0;
            pend_data[k] = 32'd0;
            pend_due[k] = 0;
            starve[k] = 0;
            last_dm[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        // reset held with both requests pending; grant right after release
        repeat (2) cycle();
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        cycle();
        for (int k = 0; k < NI; k++) chk("rst_release_gnt", 64'(saw_dg[k]), 64'd1);
        drop_granted();
        run_until_idle(40);

        // single fetch, latency 1
        mmem[0][17] = 32'h0000006f;
        emem[0][17] = 32'h0000006f;
        if_req[0] = 1'b1;
        if_addr[0] = 32'h44;
        run_until_idle(20);

        // eight back-to-back fetches
        for (int w = 0; w < 8; w++) begin
            mmem[0][w] = 32'h1000 + 32'(w);
            emem[0][w] = 32'h1000 + 32'(w);
        end
        if_req[0] = 1'b1;
        if_addr[0] = 32'h0;
        nrv = 0; first = -1; last = -1; ni = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (saw_irv[0]) begin
                nrv++;
                if (first < 0) first = i;
                last = i;
            end
            if (saw_ig[0]) begin
                ni++;
                if (ni == 8) if_req[0] = 1'b0;
                else if_addr[0] = if_addr[0] + 32'd4;
            end
        end
        chk("b2b_rvalid_count", 64'(nrv), 64'd8);
        chk("b2b_rvalid_span",  64'(last - first), 64'd7);

        // continuous contention
        if_req[0] = 1'b1;
        if_addr[0] = 32'h8;
        set_dm(0, 1'b0, 32'h10, 32'd0, 4'd0);
        nd = 0; ni = 0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (saw_dg[0]) begin
                nd++;
                dm_addr[0] = AW'($urandom_range(0, 63));
            end
            if (saw_ig[0]) begin
                ni++;
                if_addr[0] = AW'($urandom_range(0, 63));
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk("contention_dm_grants", 64'(nd), 64'd13);
        chk("contention_if_grants", 64'(ni), 64'd12);
`else
        chk("contention_dm_grants", 64'(nd), 64'd20);
        chk("contention_if_grants", 64'(ni), 64'd5);
`endif
        run_until_idle(20);

        // store then load on the latency-3 instance
        set_dm(1, 1'b1, 32'h100, 32'hdeadbeef, 4'b1111);
        run_until_idle(20);
        set_dm(1, 1'b0, 32'h100, 32'h0, 4'b0000);
        run_until_idle(20);
        chk("store_load_mem", 64'(emem[1][64]), 64'h00000000deadbeef);

        // reset one cycle after a load grant drops the access
        set_dm(1, 1'b0, 32'h20, 32'h0, 4'b0000);
        nd = 0;
        while (dm_req[1] && (nd < 10)) begin
            cycle();
            drop_granted();
            nd++;
        end
        chk("rst_mid_gnt_seen", 64'(dm_req[1]), 64'd0);
        rst[1] = 1'b1;
        cycle();
        rst[1] = 1'b0;
        nrv = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (saw_drv[1]) nrv++;
        end
        chk("rst_mid_no_rvalid", 64'(nrv), 64'd0);
        if_req[1] = 1'b1;
        if_addr[1] = 32'h30;
        run_until_idle(20);

        // random traffic on both instances
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < NI; k++) begin
                rst[k] = ($urandom_range(0, 49) == 0);
                if (!if_req[k] && ($urandom_range(0, 1) == 1)) begin
                    if_req[k] = 1'b1;
                    if_addr[k] = AW'($urandom_range(0, 63));
                end
                if (!dm_req[k] && ($urandom_range(0, 1) == 1)) begin
                    set_dm(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                           $urandom(), 4'($urandom_range(0, 15)));
                end
            end
            cycle();
            drop_granted();
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        run_until_idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
